gn_axis_dwconv: RTL and testbench
=================================

GN_AXIS_DWCONV -- requirements
Module: gn_axis_dwconv

Interface
REQ-001 SHALL have parameter P_S_AXIS_DWIDTH, default 32, slave data width in bits (multiple of 8).
REQ-002 SHALL have parameter P_M_AXIS_DWIDTH, default 8, master data width in bits (multiple of 8); R = P_S_AXIS_DWIDTH/P_M_AXIS_DWIDTH, an integer in 1..16.
REQ-003 SHALL have parameter P_MSB_FIRST, default 0, where 0 means lowest slice emitted first and 1 means highest slice emitted first.
REQ-004 SHALL have parameter P_KEEP_EN, default 1, where 1 means skip output beats whose tkeep slice is all-zero.
REQ-005 SHALL have ports: clk in 1, the single clock; reset_n in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: s_axis_tdata in P_S_AXIS_DWIDTH; s_axis_tkeep in P_S_AXIS_DWIDTH/8; s_axis_tlast in 1; s_axis_tvalid in 1; s_axis_tready out 1.
REQ-007 SHALL have ports: m_axis_tdata out P_M_AXIS_DWIDTH; m_axis_tkeep out P_M_AXIS_DWIDTH/8; m_axis_tlast out 1; m_axis_tvalid out 1; m_axis_tready in 1.
REQ-008 SHALL have port pkt_cnt out 16, the count of completed output packets (m tlast transfers).

Function
REQ-009 SHALL hold one accepted input word (data, keep, last) in an internal buffer with a beat index 0..R-1 and a busy flag.
REQ-010 SHALL accept input (s_axis_tvalid && s_axis_tready) only when s_axis_tready = !busy || (final beat pending && m_axis_tvalid && m_axis_tready), so back-to-back words run at one output beat per cycle with no bubble.
REQ-011 SHALL present the first output beat of an accepted word with m_axis_tvalid high on the cycle after acceptance (latency 1); there is no combinational path from s_axis_* to m_axis_*.
REQ-012 SHALL output, for beat index i, slice i (P_MSB_FIRST=0) or slice R-1-i (P_MSB_FIRST=1) of the buffered data, together with the matching keep slice.
REQ-013 SHALL hold m_axis_tdata, m_axis_tkeep, m_axis_tlast and m_axis_tvalid stable while m_axis_tvalid && !m_axis_tready.
REQ-014 SHALL, with P_KEEP_EN=1, advance the index directly to the next slice with a non-zero keep, and treat the final beat as the last slice with non-zero keep.
REQ-015 SHALL, with P_KEEP_EN=0, emit all R beats unconditionally.
REQ-016 SHALL assert m_axis_tlast only on the final beat of a word accepted with s_axis_tlast=1.
REQ-017 SHALL, with P_KEEP_EN=1 and an all-zero input keep, drop the word (no output beats, busy stays low, s_axis_tready stays high) when tlast=0, and emit one beat with tkeep=0 and tlast=1 when tlast=1.
REQ-018 SHALL pass data, keep and last straight through with one register stage when R=1.
REQ-019 SHALL increment pkt_cnt by 1 on each m_axis_tlast transfer, wrapping from 16'hFFFF to 0.

Reset
REQ-020 SHALL, while reset_n=0 (asserted asynchronously), force m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, pkt_cnt=0, busy=0, index=0 and s_axis_tready=0.
REQ-021 SHALL discard any partially emitted word when reset is asserted mid-operation, and SHALL raise s_axis_tready on the first clk edge after reset_n deasserts.

Verification
REQ-022 SHALL pass this case: 32->8, LSB-first, m_tready=1, input 0x44332211 keep=F last=1 -> beats 11,22,33,44 on 4 consecutive cycles, tlast on 44, pkt_cnt=1.
REQ-023 SHALL pass this case: P_MSB_FIRST=1, same word -> beats 44,33,22,11.
REQ-024 SHALL pass this case: keep=4'b0101, last=1 -> 2 beats, 11 then 33, tlast on 33; keep=0 last=0 -> no beats; keep=0 last=1 -> one beat with tkeep=0, tlast=1.
REQ-025 SHALL pass this case: 100 random words, random tvalid, m_tready random 30% duty -> output stream equals the reference byte sequence, tvalid/tdata stable under backpressure, and zero idle cycles between words when m_tready=1.
REQ-026 SHALL pass this case: reset_n pulsed low after beat 2 of 4 -> outputs zero immediately, remaining beats never appear, and the next word converts correctly.
REQ-027 SHALL pass this case: 65537 single-beat packets -> pkt_cnt=1 after wrap.

Source files
------------

// File: rtl/gn_axis_dwconv.sv
// -----------------------------------------------------------------------------
// gn_axis_dwconv -- AXI4-Stream width down-converter.
//
// Takes one wide input word and sends it out as R = P_S_AXIS_DWIDTH /
// P_M_AXIS_DWIDTH narrow beats. The slice order is selected by P_MSB_FIRST.
// When P_KEEP_EN is set, slices whose tkeep is all-zero are skipped. An input
// word with no kept bytes is dropped, unless it carries tlast. In that case a
// single empty beat (tkeep=0, tlast=1) is sent so the packet boundary is not
// lost.
//
// Ports
//   clk, reset_n           single clock, asynchronous active-low reset
//   s_axis_tdata/tkeep/tlast/tvalid/tready   wide slave stream
//   m_axis_tdata/tkeep/tlast/tvalid/tready   narrow master stream
//   pkt_cnt                count of m_axis tlast transfers (wraps at 16 bits)
//
// Timing: the first beat of an accepted word is valid on the next cycle. A new
// word is accepted in the same cycle that the final beat of the current word
// transfers, so back-to-back words have no bubble between them.
// -----------------------------------------------------------------------------
module gn_axis_dwconv #(
   parameter int P_S_AXIS_DWIDTH = 32,
   parameter int P_M_AXIS_DWIDTH = 8,
   parameter int P_MSB_FIRST     = 0,
   parameter int P_KEEP_EN       = 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [P_S_AXIS_DWIDTH-1:0]   s_axis_tdata,
   input  logic [P_S_AXIS_DWIDTH/8-1:0] s_axis_tkeep,
   input  logic                         s_axis_tlast,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   output logic [P_M_AXIS_DWIDTH-1:0]   m_axis_tdata,
   output logic [P_M_AXIS_DWIDTH/8-1:0] m_axis_tkeep,
   output logic                         m_axis_tlast,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [15:0]                  pkt_cnt
);

   localparam int R    = P_S_AXIS_DWIDTH / P_M_AXIS_DWIDTH;
   localparam int SKB  = P_S_AXIS_DWIDTH / 8;
   localparam int MKB  = P_M_AXIS_DWIDTH / 8;
   localparam int IDXW = (R > 1) ? $clog2(R) : 1;
   // With R=1 the block is a plain register stage, so keep-based skipping is
   // turned off even when P_KEEP_EN is set.
   localparam bit KEEP_SKIP = (P_KEEP_EN != 0) && (R > 1);

   logic [P_S_AXIS_DWIDTH-1:0] data_reg;
   logic [SKB-1:0]             keep_reg;
   logic                       last_reg;
   logic [IDXW-1:0]            idx_reg;
   logic                       busy_reg;
   logic                       ready_en_reg;
   logic [15:0]                pkt_cnt_reg;

   // Buffered and incoming slices, re-indexed by beat (emission) order.
   logic [P_M_AXIS_DWIDTH-1:0] beat_data [R];
   logic [MKB-1:0]             beat_keep [R];
   logic [R-1:0]               buf_nz;
   logic [R-1:0]               in_nz;

   for (genvar gi = 0; gi < R; gi++) begin : g_slice
      localparam int SL = (P_MSB_FIRST != 0) ? (R - 1 - gi) : gi;
      assign beat_data[gi] = data_reg[SL*P_M_AXIS_DWIDTH +: P_M_AXIS_DWIDTH];
      assign beat_keep[gi] = keep_reg[SL*MKB +: MKB];
      // Without skipping, every beat counts as "present".
      assign buf_nz[gi]    = KEEP_SKIP ? (|keep_reg[SL*MKB +: MKB]) : 1'b1;
      assign in_nz[gi]     = KEEP_SKIP ? (|s_axis_tkeep[SL*MKB +: MKB]) : 1'b1;
   end

   logic            has_next;
   logic [IDXW-1:0] next_idx;
   logic            in_any;
   logic [IDXW-1:0] first_idx;

   // Find the next present beat after the current one, and the first present
   // beat of the incoming word. The loops scan downward so that the lowest
   // matching index is the one that remains.
   always_comb begin
      has_next  = 1'b0;
      next_idx  = idx_reg;
      in_any    = 1'b0;
      first_idx = '0;
      for (int j = R - 1; j >= 0; j--) begin
         if ((j > int'(idx_reg)) && buf_nz[j]) begin
            has_next = 1'b1;
            next_idx = IDXW'(j);
         end
         if (in_nz[j]) begin
            in_any    = 1'b1;
            first_idx = IDXW'(j);
         end
      end
   end

   logic is_final;
   logic beat_xfer;
   logic final_xfer;
   logic accept;
   logic drop_word;

   assign is_final   = !has_next;
   assign beat_xfer  = busy_reg && m_axis_tready;
   assign final_xfer = beat_xfer && is_final;
   // ready_en_reg keeps tready low during reset and for the first edge after it.
   assign s_axis_tready = ready_en_reg && (!busy_reg || final_xfer);
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign drop_word     = KEEP_SKIP && !in_any && !s_axis_tlast;

   // The outputs are decoded directly from registers only. Because nothing
   // changes while stalled, they hold steady under backpressure.
   assign m_axis_tvalid = busy_reg;
   assign m_axis_tdata  = beat_data[idx_reg];
   assign m_axis_tkeep  = beat_keep[idx_reg];
   assign m_axis_tlast  = busy_reg && last_reg && is_final;
   assign pkt_cnt       = pkt_cnt_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_reg     <= '0;
         keep_reg     <= '0;
         last_reg     <= 1'b0;
         idx_reg      <= '0;
         busy_reg     <= 1'b0;
         ready_en_reg <= 1'b0;
         pkt_cnt_reg  <= '0;
      end else begin
         ready_en_reg <= 1'b1;
         if (final_xfer && last_reg) begin
            pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
         end
         if (accept && !drop_word) begin
            data_reg <= s_axis_tdata;
            keep_reg <= s_axis_tkeep;
            last_reg <= s_axis_tlast;
            idx_reg  <= first_idx;
            busy_reg <= 1'b1;
         end else if (final_xfer) begin
            // The word is finished. A dropped word accepted in this same
            // cycle leaves the buffer empty.
            idx_reg  <= '0;
            busy_reg <= 1'b0;
         end else if (beat_xfer) begin
            idx_reg <= next_idx;
         end
      end
   end

endmodule

// File: tb/tb_gn_axis_dwconv.sv
// -----------------------------------------------------------------------------
// tb_gn_axis_dwconv -- self-checking bench for gn_axis_dwconv (32 -> 8).
// Two instances share the slave stream: one LSB-first, one MSB-first.
// Expected beats come from a byte-level model and go into per-instance queues.
// A monitor pops the queues and compares them against the beats the DUTs
// actually transfer.
// -----------------------------------------------------------------------------
module tb_gn_axis_dwconv;

   typedef struct packed {
      logic [7:0] d;
      logic       k;
      logic       l;
   } beat_t;

   logic        clk;
   logic        reset_n;
   logic [31:0] s_tdata;
   logic [3:0]  s_tkeep;
   logic        s_tlast;
   logic        s_tvalid;
   logic        s_tready, s_tready2;
   logic [7:0]  m_tdata, m2_tdata;
   logic        m_tkeep, m2_tkeep;
   logic        m_tlast, m2_tlast;
   logic        m_tvalid, m2_tvalid;
   logic        m_tready;
   logic [15:0] pkt_cnt, pkt_cnt2;

   beat_t q_lsb[$];
   beat_t q_msb[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    exp_pkts = 0;
   int    ready_pct = 100;
   bit    gap_mode = 0;
   bit    gap_seen = 0;
   int    gap_cnt = 0;

   gn_axis_dwconv #(.P_S_AXIS_DWIDTH(32), .P_M_AXIS_DWIDTH(8),
                    .P_MSB_FIRST(0), .P_KEEP_EN(1)) dut_lsb (
      .clk(clk), .reset_n(reset_n),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .pkt_cnt(pkt_cnt));

   gn_axis_dwconv #(.P_S_AXIS_DWIDTH(32), .P_M_AXIS_DWIDTH(8),
                    .P_MSB_FIRST(1), .P_KEEP_EN(1)) dut_msb (
      .clk(clk), .reset_n(reset_n),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready2),
      .m_axis_tdata(m2_tdata), .m_axis_tkeep(m2_tkeep), .m_axis_tlast(m2_tlast),
      .m_axis_tvalid(m2_tvalid), .m_axis_tready(m_tready),
      .pkt_cnt(pkt_cnt2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Master backpressure: m_tready is high ready_pct percent of the time.
   initial begin
      m_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         m_tready = ($urandom_range(99) < ready_pct);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model, working on bytes: walk the byte lanes in emission order
   // and keep the lanes that are enabled. tlast goes on the last kept lane. An
   // empty word that ends a packet still produces one empty beat.
   task automatic push_expected(input logic [31:0] d, input logic [3:0] k, input logic l);
      for (int order = 0; order < 2; order++) begin
         beat_t lst[$];
         beat_t b;
         for (int i = 0; i < 4; i++) begin
            int s;
            s = (order == 1) ? 3 - i : i;
            if (k[s]) begin
               b.d = d[s*8 +: 8];
               b.k = 1'b1;
               b.l = 1'b0;
               lst.push_back(b);
            end
         end
         if (lst.size() == 0) begin
            if (l) begin
               b.d = 8'h00;
               b.k = 1'b0;
               b.l = 1'b1;
               lst.push_back(b);
            end
         end else begin
            b = lst.pop_back();
            b.l = l;
            lst.push_back(b);
         end
         foreach (lst[n]) begin
            if (order == 0) q_lsb.push_back(lst[n]);
            else            q_msb.push_back(lst[n]);
         end
      end
      if (l) exp_pkts++;
   endtask

   task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l, input int gap);
      int waited;
      s_tvalid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = l;
      s_tvalid = 1'b1;
      waited   = 0;
      forever begin
         @(negedge clk);
         if (s_tready) break;
         waited++;
         if (waited > 2000) break;
      end
      if (s_tready) begin
         push_expected(d, k, l);
         check("tready_msb_inst", {31'd0, s_tready2}, 32'd1);
      end else begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: s_tready stuck at %b, expected 1", s_tready);
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q_lsb.size() != 0 || q_msb.size() != 0) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      n_tests++;
      if (t >= 5000) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d/%0d beats outstanding, expected 0", q_lsb.size(), q_msb.size());
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Monitor: every transferred beat is compared with the head of its queue.
   // The bench also checks that outputs hold while stalled, and counts
   // bubbles during back-to-back streaming.
   bit         stall_prev = 0;
   logic [7:0] hold_d;
   logic       hold_k, hold_l;
   beat_t      e1, e2;

   always @(negedge clk) begin
      if (reset_n) begin
         if (stall_prev) begin
            check("hold_tvalid", {31'd0, m_tvalid}, 32'd1);
            check("hold_tdata", {24'd0, m_tdata}, {24'd0, hold_d});
            check("hold_tkeep", {31'd0, m_tkeep}, {31'd0, hold_k});
            check("hold_tlast", {31'd0, m_tlast}, {31'd0, hold_l});
         end
         if (m_tvalid && m_tready) begin
            if (q_lsb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_beat_lsb: got data %h, expected no beat", m_tdata);
            end else begin
               e1 = q_lsb.pop_front();
               check("lsb_tkeep", {31'd0, m_tkeep}, {31'd0, e1.k});
               check("lsb_tlast", {31'd0, m_tlast}, {31'd0, e1.l});
               if (e1.k) check("lsb_tdata", {24'd0, m_tdata}, {24'd0, e1.d});
            end
         end
         if (m2_tvalid && m_tready) begin
            if (q_msb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_beat_msb: got data %h, expected no beat", m2_tdata);
            end else begin
               e2 = q_msb.pop_front();
               check("msb_tkeep", {31'd0, m2_tkeep}, {31'd0, e2.k});
               check("msb_tlast", {31'd0, m2_tlast}, {31'd0, e2.l});
               if (e2.k) check("msb_tdata", {24'd0, m2_tdata}, {24'd0, e2.d});
            end
         end
         if (gap_mode) begin
            if (m_tvalid) gap_seen = 1'b1;
            else if (gap_seen && q_lsb.size() != 0) gap_cnt++;
         end
         stall_prev = m_tvalid && !m_tready;
         hold_d = m_tdata;
         hold_k = m_tkeep;
         hold_l = m_tlast;
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n  = 1'b0;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = 1'b0;
      #2;
      check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
      check("rst_tdata", {24'd0, m_tdata}, 32'd0);
      check("rst_tkeep", {31'd0, m_tkeep}, 32'd0);
      check("rst_tlast", {31'd0, m_tlast}, 32'd0);
      check("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
      check("rst_tready", {31'd0, s_tready}, 32'd0);
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("tready_after_reset", {31'd0, s_tready}, 32'd1);

      // Single full word: latency 1, four beats, tlast on the final beat.
      send_word(32'h44332211, 4'hF, 1'b1, 0);
      check("latency_tvalid", {31'd0, m_tvalid}, 32'd1);
      check("latency_tdata", {24'd0, m_tdata}, 32'h11);
      check("latency_msb_tdata", {24'd0, m2_tdata}, 32'h44);
      drain();
      check("pkt_cnt_single", {16'd0, pkt_cnt}, exp_pkts);

      // Sparse keep, dropped empty word, and empty word ending a packet.
      send_word(32'h44332211, 4'b0101, 1'b1, 0);
      drain();
      send_word(32'h55667788, 4'b0000, 1'b0, 0);
      check("drop_tvalid", {31'd0, m_tvalid}, 32'd0);
      check("drop_tready", {31'd0, s_tready}, 32'd1);
      drain();
      send_word(32'h99AABBCC, 4'b0000, 1'b1, 0);
      drain();
      check("pkt_cnt_keep", {16'd0, pkt_cnt}, exp_pkts);

      // Back-to-back full words with m_tready=1 must stream without bubbles.
      gap_mode = 1'b1;
      gap_seen = 1'b0;
      gap_cnt  = 0;
      for (int w = 0; w < 6; w++) send_word($urandom, 4'hF, 1'($urandom_range(1)), 0);
      drain();
      gap_mode = 1'b0;
      check("no_bubble_cycles", gap_cnt, 32'd0);

      // Random words, random gaps, 30% output ready.
      ready_pct = 30;
      for (int w = 0; w < 100; w++)
         send_word($urandom, 4'($urandom_range(15)), 1'($urandom_range(1)), $urandom_range(2));
      drain();
      ready_pct = 100;
      check("pkt_cnt_random", {16'd0, pkt_cnt}, exp_pkts);
      check("pkt_cnt_random_msb", {16'd0, pkt_cnt2}, exp_pkts);

      // Reset after two of four beats: the remainder is discarded.
      send_word(32'h44332211, 4'hF, 1'b1, 0);
      @(posedge clk);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_tvalid", {31'd0, m_tvalid}, 32'd0);
      check("midrst_tdata", {24'd0, m_tdata}, 32'd0);
      check("midrst_tlast", {31'd0, m_tlast}, 32'd0);
      check("midrst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
      check("midrst_tready", {31'd0, s_tready}, 32'd0);
      q_lsb.delete();
      q_msb.delete();
      exp_pkts = 0;
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_tready_after", {31'd0, s_tready}, 32'd1);
      repeat (5) @(posedge clk);
      #1;
      send_word(32'hDDCCBBAA, 4'hF, 1'b1, 0);
      drain();
      check("pkt_cnt_after_midrst", {16'd0, pkt_cnt}, 32'd1);

      // 65537 single-beat packets: the counter wraps back around to 1.
      reset_n = 1'b0;
      #3;
      q_lsb.delete();
      q_msb.delete();
      exp_pkts = 0;
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      for (int w = 0; w < 65537; w++) send_word($urandom, 4'b0001, 1'b1, 0);
      drain();
      check("pkt_cnt_wrap", {16'd0, pkt_cnt}, exp_pkts % 65536);
      check("pkt_cnt_wrap_msb", {16'd0, pkt_cnt2}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
